// File: rtl/lc3b_mem_arbiter_if.sv
// Purpose: bundles the split CPU instruction/data memory ports and the single
//          physical memory port that the arbiter sits between.
// Ports:   slave modport = arbiter view (CPU requests and pmem responses in; CPU
//          responses and pmem strobes out); master modport = the opposite side.
interface lc3b_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // instruction port
  logic                  instruction_request;
  logic [ADDR_WIDTH-1:0] instruction_address;
  logic                  instruction_response;
  logic [DATA_WIDTH-1:0] instr;

  // data port
  logic                  data_request;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [BE_WIDTH-1:0]   mem_byte_enable;
  logic                  data_response;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // physical memory port
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [DATA_WIDTH-1:0] pmem_wdata;
  logic [BE_WIDTH-1:0]   pmem_byte_enable;
  logic                  pmem_resp;
  logic [DATA_WIDTH-1:0] pmem_rdata;

  modport slave (
    input  instruction_request, instruction_address,
    output instruction_response, instr,
    input  data_request, write_enable, mem_address, write_data, mem_byte_enable,
    output data_response, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output instruction_request, instruction_address,
    input  instruction_response, instr,
    output data_request, write_enable, mem_address, write_data, mem_byte_enable,
    input  data_response, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// Purpose: merges CPU instruction and data ports onto one physical memory port,
//          one outstanding transaction, fair (round-robin) or fixed-priority ties.
// Latency: request in IDLE cycle t -> strobe from t+1; pmem_resp at k -> response
//          pulse at k+1 -> IDLE at k+2 (3 cycles per zero-wait transaction).
// Backpressure: requesters hold their request until their response pulse; the
//          physical side stalls indefinitely by withholding pmem_resp.
// Ports:   clk, rst (async active-high); bus = lc3b_mem_arbiter_if.slave.
module lc3b_mem_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter bit ROUND_ROBIN   = 1'b1,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input logic                clk,
  input logic                rst,
  lc3b_mem_arbiter_if.slave  bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t                state;
  state_t                state_next;
  port_t                 last_grant;
  port_t                 owner;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_WIDTH-1:0]   lat_be;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  grant_any;
  logic                  grant_d;
  logic                  serving;

  // Grant decision and next state. The grant is only consumed in IDLE.
  always_comb begin
    grant_any  = bus.instruction_request | bus.data_request;
    grant_d    = bus.data_request;
    state_next = state;
    if (bus.instruction_request && bus.data_request) begin
      if (ROUND_ROBIN) grant_d = (last_grant == PORT_I);
      else             grant_d = DATA_PRIORITY;
    end
    case (state)
      IDLE:             if (grant_any) state_next = grant_d ? SERVE_D : SERVE_I;
      SERVE_I, SERVE_D: if (bus.pmem_resp) state_next = RESP;
      RESP:             state_next = IDLE;  // never grants from RESP
      default:          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant  <= PORT_I;
      owner       <= PORT_I;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
      instr_q     <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        last_grant <= grant_d ? PORT_D : PORT_I;
        owner      <= grant_d ? PORT_D : PORT_I;
        if (grant_d) begin
          lat_addr  <= bus.mem_address;
          lat_we    <= bus.write_enable;
          lat_wdata <= bus.write_data;
          // loads always read the full word
          lat_be    <= bus.write_enable ? bus.mem_byte_enable : '1;
        end else begin
          lat_addr  <= bus.instruction_address;
          lat_we    <= 1'b0;
          lat_wdata <= '0;
          lat_be    <= '1;
        end
      end
      if (state == SERVE_I && bus.pmem_resp)
        instr_q <= bus.pmem_rdata;
      // stores leave the last load value in place
      if (state == SERVE_D && bus.pmem_resp && !lat_we)
        mem_rdata_q <= bus.pmem_rdata;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign serving                  = (state == SERVE_I) || (state == SERVE_D);
  assign bus.pmem_read            = serving && !lat_we;
  assign bus.pmem_write           = serving && lat_we;
  assign bus.pmem_address         = lat_addr;
  assign bus.pmem_wdata           = lat_wdata;
  assign bus.pmem_byte_enable     = lat_be;
  assign bus.instruction_response = (state == RESP) && (owner == PORT_I);
  assign bus.data_response        = (state == RESP) && (owner == PORT_D);
  assign bus.instr                = instr_q;
  assign bus.mem_rdata            = mem_rdata_q;
endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Bench for lc3b_mem_arbiter: table vectors, directed reset/ignore sequences,
// a fixed-priority instance, and randomized transactions against a model.
module tb_lc3b_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lc3b_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
  lc3b_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) fbus ();

  lc3b_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ROUND_ROBIN(1'b1), .DATA_PRIORITY(1'b1))
    dut_rr (.clk(clk), .rst(rst), .bus(bus));
  lc3b_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .ROUND_ROBIN(1'b0), .DATA_PRIORITY(1'b0))
    dut_fp (.clk(clk), .rst(rst), .bus(fbus));

  typedef struct {
    bit          rst_first;
    logic        req_i, req_d, we;
    logic [15:0] iaddr, daddr, wdata;
    logic [1:0]  be;
    int          wait_n;
    logic [15:0] rdata;
    logic        exp_d;
    logic [15:0] exp_addr, exp_wdata;
    logic [1:0]  exp_be;
    logic [15:0] exp_instr, exp_mrdata;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(bit r, logic ri, logic rd, logic we, logic [15:0] ia, logic [15:0] da,
                              logic [15:0] wd, logic [1:0] be, int wn, logic [15:0] rdat,
                              logic ed, logic [15:0] ea, logic [1:0] ebe,
                              logic [15:0] ei, logic [15:0] em);
    vec_t v;
    v.rst_first = r; v.req_i = ri; v.req_d = rd; v.we = we; v.iaddr = ia; v.daddr = da;
    v.wdata = wd; v.be = be; v.wait_n = wn; v.rdata = rdat; v.exp_d = ed; v.exp_addr = ea;
    v.exp_wdata = wd; v.exp_be = ebe; v.exp_instr = ei; v.exp_mrdata = em;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.instruction_request = 1'b0; bus.data_request = 1'b0; bus.pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transaction: present requests, check the latched strobe, stall
  // while scrambling CPU inputs, respond, check the pulse and the return to idle.
  task automatic run_txn(input vec_t v);
    logic exp_wr;
    exp_wr = v.exp_d && v.we;
    if (v.rst_first) do_reset();
    @(negedge clk);
    bus.instruction_request = v.req_i; bus.instruction_address = v.iaddr;
    bus.data_request = v.req_d; bus.write_enable = v.we; bus.mem_address = v.daddr;
    bus.write_data = v.wdata; bus.mem_byte_enable = v.be;
    @(posedge clk); #1;
    chk("strobe_read", bus.pmem_read, !exp_wr);
    chk("strobe_write", bus.pmem_write, exp_wr);
    chk("grant_addr", bus.pmem_address, v.exp_addr);
    chk("grant_be", bus.pmem_byte_enable, v.exp_be);
    if (exp_wr) chk("grant_wdata", bus.pmem_wdata, v.exp_wdata);
    for (int w = 0; w < v.wait_n; w++) begin
      @(negedge clk);
      bus.instruction_address = 16'($urandom_range(0, 16'hFFFF));
      bus.mem_address = 16'($urandom_range(0, 16'hFFFF));
      bus.write_data = 16'($urandom_range(0, 16'hFFFF));
      @(posedge clk); #1;
      chk("stall_addr", bus.pmem_address, v.exp_addr);
      chk("stall_strobe", bus.pmem_read | bus.pmem_write, 1'b1);
      chk("stall_noresp", bus.instruction_response | bus.data_response, 1'b0);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = v.rdata;
    @(posedge clk); #1;
    chk("resp_strobes_off", bus.pmem_read | bus.pmem_write, 1'b0);
    chk("resp_i", bus.instruction_response, !v.exp_d);
    chk("resp_d", bus.data_response, v.exp_d);
    chk("instr", bus.instr, v.exp_instr);
    chk("mem_rdata", bus.mem_rdata, v.exp_mrdata);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    if (v.exp_d) bus.data_request = 1'b0;
    else         bus.instruction_request = 1'b0;
    @(posedge clk); #1;
    chk("idle_noresp", bus.instruction_response | bus.data_response, 1'b0);
    chk("idle_strobes", bus.pmem_read | bus.pmem_write, 1'b0);
    chk("idle_instr", bus.instr, v.exp_instr);
    chk("idle_mem_rdata", bus.mem_rdata, v.exp_mrdata);
  endtask

  vec_t tbl[7];
  vec_t v;
  // reference model state
  logic        last_d, pend_i, pend_d, p_we;
  logic [15:0] p_iaddr, p_daddr, p_wdata, e_instr, e_mrd, rd;
  logic [1:0]  p_be;
  logic        win_d;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             rst ri rd we iaddr     daddr     wdata     be    wn rdata     exp_d addr      be    instr     mrdata
    tbl[0] = mk(1, 1, 0, 0, 16'h3000, 16'h0000, 16'h0000, 2'b00, 1, 16'h1234, 0, 16'h3000, 2'b11, 16'h1234, 16'h0000);
    tbl[1] = mk(0, 0, 1, 1, 16'h0000, 16'h0040, 16'hBEEF, 2'b01, 0, 16'h5555, 1, 16'h0040, 2'b01, 16'h1234, 16'h0000);
    tbl[2] = mk(0, 1, 1, 0, 16'h3002, 16'h0100, 16'h0000, 2'b00, 2, 16'h0AB1, 0, 16'h3002, 2'b11, 16'h0AB1, 16'h0000);
    tbl[3] = mk(0, 0, 1, 0, 16'h0000, 16'h0100, 16'h0000, 2'b00, 0, 16'hCAFE, 1, 16'h0100, 2'b11, 16'h0AB1, 16'hCAFE);
    tbl[4] = mk(1, 1, 1, 1, 16'h3010, 16'h0200, 16'h1111, 2'b10, 0, 16'h0000, 1, 16'h0200, 2'b10, 16'h0000, 16'h0000);
    tbl[5] = mk(0, 1, 1, 0, 16'h3010, 16'h0202, 16'h0000, 2'b00, 0, 16'h7777, 0, 16'h3010, 2'b11, 16'h7777, 16'h0000);
    tbl[6] = mk(0, 0, 1, 0, 16'h0000, 16'h0202, 16'h0000, 2'b00, 3, 16'h9999, 1, 16'h0202, 2'b11, 16'h7777, 16'h9999);

    bus.instruction_request = 0; bus.instruction_address = 0; bus.data_request = 0;
    bus.write_enable = 0; bus.mem_address = 0; bus.write_data = 0; bus.mem_byte_enable = 0;
    bus.pmem_resp = 0; bus.pmem_rdata = 0;
    fbus.instruction_request = 0; fbus.instruction_address = 0; fbus.data_request = 0;
    fbus.write_enable = 0; fbus.mem_address = 0; fbus.write_data = 0; fbus.mem_byte_enable = 0;
    fbus.pmem_resp = 0; fbus.pmem_rdata = 0;

    do_reset();
    #1;
    chk("rst_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("rst_resps", {bus.instruction_response, bus.data_response}, 2'b00);
    chk("rst_addr", bus.pmem_address, 16'h0000);
    chk("rst_be", bus.pmem_byte_enable, 2'b00);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_mem_rdata", bus.mem_rdata, 16'h0000);

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // pmem_resp while idle with nothing requested is ignored
    @(negedge clk);
    bus.pmem_resp = 1'b1; bus.pmem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    chk("stray_resp_noresp", bus.instruction_response | bus.data_response, 1'b0);
    chk("stray_resp_strobes", bus.pmem_read | bus.pmem_write, 1'b0);
    @(negedge clk); bus.pmem_resp = 1'b0;
    @(posedge clk); #1;
    chk("stray_resp_instr", bus.instr, 16'h7777);
    chk("stray_resp_mrdata", bus.mem_rdata, 16'h9999);

    // async reset while a fetch strobe is high
    @(negedge clk);
    bus.instruction_request = 1'b1; bus.instruction_address = 16'h5000;
    @(posedge clk); #1;
    chk("pre_rst_read", bus.pmem_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_read", bus.pmem_read, 1'b0);
    chk("async_rst_instr", bus.instr, 16'h0000);
    bus.instruction_request = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {bus.pmem_read, bus.pmem_write,
                             bus.instruction_response, bus.data_response}, 4'b0000);
    end

    // fixed priority, instruction wins ties
    @(negedge clk);
    fbus.instruction_request = 1'b1; fbus.instruction_address = 16'h4000;
    fbus.data_request = 1'b1; fbus.write_enable = 1'b1; fbus.mem_address = 16'h0050;
    fbus.write_data = 16'hA5A5; fbus.mem_byte_enable = 2'b11;
    @(posedge clk); #1;
    chk("fp_first_read", fbus.pmem_read, 1'b1);
    chk("fp_first_addr", fbus.pmem_address, 16'h4000);
    @(negedge clk); fbus.pmem_resp = 1'b1; fbus.pmem_rdata = 16'h4321;
    @(posedge clk); #1;
    chk("fp_resp_i", {fbus.instruction_response, fbus.data_response}, 2'b10);
    chk("fp_instr", fbus.instr, 16'h4321);
    @(negedge clk); fbus.pmem_resp = 1'b0; fbus.instruction_request = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("fp_second_write", fbus.pmem_write, 1'b1);
    chk("fp_second_addr", fbus.pmem_address, 16'h0050);
    @(negedge clk); fbus.pmem_resp = 1'b1;
    @(posedge clk); #1;
    chk("fp_resp_d", {fbus.instruction_response, fbus.data_response}, 2'b01);
    @(negedge clk); fbus.pmem_resp = 1'b0; fbus.data_request = 1'b0;

    // randomized transactions against the model
    do_reset();
    last_d = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
    e_instr = 16'h0000; e_mrd = 16'h0000;
    p_iaddr = 0; p_daddr = 0; p_wdata = 0; p_be = 0; p_we = 0;
    for (int n = 0; n < 60; n++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) begin
        pend_i = 1'b1; p_iaddr = 16'($urandom_range(0, 16'hFFFF));
      end
      if (!pend_d && ($urandom_range(0, 1) == 1 || !pend_i)) begin
        pend_d = 1'b1; p_we = 1'($urandom_range(0, 1));
        p_daddr = 16'($urandom_range(0, 16'hFFFF));
        p_wdata = 16'($urandom_range(0, 16'hFFFF));
        p_be = 2'($urandom_range(0, 3));
      end
      // tie: the port not granted last time; otherwise whoever asks
      win_d = (pend_i && pend_d) ? !last_d : pend_d;
      rd = 16'($urandom_range(0, 16'hFFFF));
      if (!win_d) e_instr = rd;
      else if (!p_we) e_mrd = rd;
      v = mk(0, pend_i, pend_d, p_we, p_iaddr, p_daddr, p_wdata, p_be,
             $urandom_range(0, 3), rd, win_d, win_d ? p_daddr : p_iaddr,
             (win_d && p_we) ? p_be : 2'b11, e_instr, e_mrd);
      last_d = win_d;
      if (win_d) pend_d = 1'b0;
      else       pend_i = 1'b0;
      run_txn(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
